// File: rtl/ex_wbck_arb_if.sv
// ex_wbck_arb_if: bundles the writeback request side and the registered
// regfile write side of the writeback arbiter.
//   wbck_i_valid/ready : per-channel request/accept handshake (NCH bits)
//   wbck_i_wdat        : packed data, channel i at [i*XLEN +: XLEN]
//   wbck_i_rdidx       : packed index, channel i at [i*RFIDX_W +: RFIDX_W]
//   rf_wbck_o_*        : registered regfile write port (enable/data/index)
// Modports: slave = arbiter side, master = producers / regfile side.
interface ex_wbck_arb_if #(
  parameter int NCH     = 3,
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5
);
  logic [NCH-1:0]         wbck_i_valid;
  logic [NCH-1:0]         wbck_i_ready;
  logic [NCH*XLEN-1:0]    wbck_i_wdat;
  logic [NCH*RFIDX_W-1:0] wbck_i_rdidx;
  logic                   rf_wbck_o_ena;
  logic [XLEN-1:0]        rf_wbck_o_wdat;
  logic [RFIDX_W-1:0]     rf_wbck_o_rdidx;

  modport slave (
    input  wbck_i_valid, wbck_i_wdat, wbck_i_rdidx,
    output wbck_i_ready, rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx
  );

  modport master (
    output wbck_i_valid, wbck_i_wdat, wbck_i_rdidx,
    input  wbck_i_ready, rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx
  );
endinterface

// File: rtl/ex_wbck_arb.sv
// ex_wbck_arb: N-channel integer regfile writeback arbiter.
// Grants at most one valid channel per cycle (fixed priority with aging, or
// round-robin) and registers the winner onto a single regfile write port
// with one cycle of latency. Writes to x0 complete the handshake but do not
// raise the write enable.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   wbck  : ex_wbck_arb_if.slave (request handshake + registered write port)
module ex_wbck_arb #(
  parameter int NCH        = 3,
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int RR_MODE    = 0,
  parameter int STARVE_MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_wbck_arb_if.slave wbck
);

  localparam int         PTR_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [3:0] AGE_LIM = 4'(STARVE_MAX);

  logic [NCH-1:0]     valid;
  logic [NCH-1:0]     grant;
  logic [NCH-1:0]     aged;
  logic               grant_any;
  logic [PTR_W-1:0]   sel;
  logic [XLEN-1:0]    ch_wdat  [NCH];
  logic [RFIDX_W-1:0] ch_rdidx [NCH];

  logic [3:0]         cnt_q [NCH];
  logic [3:0]         cnt_d [NCH];
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               ena_q, ena_d;
  logic [XLEN-1:0]    wdat_q, wdat_d;
  logic [RFIDX_W-1:0] rdidx_q, rdidx_d;

  assign valid = wbck.wbck_i_valid;

  // Per-channel unpacking and aging counters.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign ch_wdat[gi]  = wbck.wbck_i_wdat[gi*XLEN +: XLEN];
    assign ch_rdidx[gi] = wbck.wbck_i_rdidx[gi*RFIDX_W +: RFIDX_W];
    assign aged[gi]     = valid[gi] && (cnt_q[gi] == AGE_LIM);

    always_comb begin
      cnt_d[gi] = '0;
      // Only a channel that asks and loses accumulates age; saturate at the limit.
      if (RR_MODE == 0 && valid[gi] && !grant[gi]) begin
        cnt_d[gi] = (cnt_q[gi] == AGE_LIM) ? AGE_LIM : cnt_q[gi] + 4'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) cnt_q[gi] <= '0;
      else        cnt_q[gi] <= cnt_d[gi];
    end
  end

  // Grant selection: depends only on valid and registered state.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             aged_any;
    grant     = '0;
    grant_any = 1'b0;
    sel       = '0;
    sum       = '0;
    idx       = '0;
    aged_any  = |aged;
    if (RR_MODE != 0) begin
      // Search starts at ptr and wraps; sum is one bit wider so the wrap
      // compare cannot overflow.
      for (int off = 0; off < NCH; off++) begin
        sum = {1'b0, ptr_q} + (PTR_W+1)'(off);
        if (sum >= (PTR_W+1)'(NCH)) sum = sum - (PTR_W+1)'(NCH);
        idx = sum[PTR_W-1:0];
        if (!grant_any && valid[idx]) begin
          grant[idx] = 1'b1;
          grant_any  = 1'b1;
          sel        = idx;
        end
      end
    end else begin
      // When any valid channel is aged, only aged channels compete.
      for (int i = 0; i < NCH; i++) begin
        if (!grant_any && valid[i] && (aged[i] || !aged_any)) begin
          grant[i]  = 1'b1;
          grant_any = 1'b1;
          sel       = PTR_W'(i);
        end
      end
    end
  end

  assign wbck.wbck_i_ready = grant;

  always_comb begin
    ptr_d   = ptr_q;
    ena_d   = 1'b0;
    wdat_d  = wdat_q;
    rdidx_d = rdidx_q;
    if (RR_MODE != 0 && grant_any) begin
      ptr_d = (sel == PTR_W'(NCH-1)) ? '0 : sel + 1'b1;
    end
    if (grant_any) begin
      wdat_d  = ch_wdat[sel];
      rdidx_d = ch_rdidx[sel];
      ena_d   = (ch_rdidx[sel] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      ena_q   <= 1'b0;
      wdat_q  <= '0;
      rdidx_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      ena_q   <= ena_d;
      wdat_q  <= wdat_d;
      rdidx_q <= rdidx_d;
    end
  end

  assign wbck.rf_wbck_o_ena   = ena_q;
  assign wbck.rf_wbck_o_wdat  = wdat_q;
  assign wbck.rf_wbck_o_rdidx = rdidx_q;

endmodule

// File: tb/tb_ex_wbck_arb.sv
// tb_ex_wbck_arb: directed bench for ex_wbck_arb. One fixed-priority instance
// (STARVE_MAX=8) and one round-robin instance share clock and reset.
// Inputs change on the falling edge; checks follow #1 later.
module tb_ex_wbck_arb;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0]  vf, vr;
  logic [31:0] wd [3];
  logic [4:0]  rd [3];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_wbck_arb_if #(.NCH(3), .XLEN(32), .RFIDX_W(5)) bus_f ();
  ex_wbck_arb_if #(.NCH(3), .XLEN(32), .RFIDX_W(5)) bus_r ();

  assign bus_f.wbck_i_valid = vf;
  assign bus_f.wbck_i_wdat  = {wd[2], wd[1], wd[0]};
  assign bus_f.wbck_i_rdidx = {rd[2], rd[1], rd[0]};
  assign bus_r.wbck_i_valid = vr;
  assign bus_r.wbck_i_wdat  = {wd[2], wd[1], wd[0]};
  assign bus_r.wbck_i_rdidx = {rd[2], rd[1], rd[0]};

  ex_wbck_arb #(.NCH(3), .XLEN(32), .RFIDX_W(5), .RR_MODE(0), .STARVE_MAX(8)) dut_f (
    .clk(clk), .rst_n(rst_n), .wbck(bus_f)
  );
  ex_wbck_arb #(.NCH(3), .XLEN(32), .RFIDX_W(5), .RR_MODE(1), .STARVE_MAX(8)) dut_r (
    .clk(clk), .rst_n(rst_n), .wbck(bus_r)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic out_f(input string tag, input logic e, input logic [31:0] w, input logic [4:0] r);
    chk({tag, "_ena_f"},   64'(bus_f.rf_wbck_o_ena),   64'(e));
    chk({tag, "_wdat_f"},  64'(bus_f.rf_wbck_o_wdat),  64'(w));
    chk({tag, "_rdidx_f"}, 64'(bus_f.rf_wbck_o_rdidx), 64'(r));
  endtask

  task automatic out_r(input string tag, input logic e, input logic [31:0] w, input logic [4:0] r);
    chk({tag, "_ena_r"},   64'(bus_r.rf_wbck_o_ena),   64'(e));
    chk({tag, "_wdat_r"},  64'(bus_r.rf_wbck_o_wdat),  64'(w));
    chk({tag, "_rdidx_r"}, 64'(bus_r.rf_wbck_o_rdidx), 64'(r));
  endtask

  task automatic rdy_f(input string tag, input logic [2:0] e);
    chk({tag, "_ready_f"}, 64'(bus_f.wbck_i_ready), 64'(e));
  endtask

  task automatic rdy_r(input string tag, input logic [2:0] e);
    chk({tag, "_ready_r"}, 64'(bus_r.wbck_i_ready), 64'(e));
  endtask

  initial begin
    // Reset held two cycles with every channel requesting.
    rst_n = 1'b0;
    vf = 3'b111; vr = 3'b111;
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2;
    rd[0] = 5'd1;   rd[1] = 5'd2;   rd[2] = 5'd3;
    @(negedge clk); @(negedge clk); #1;
    out_f("rst", 1'b0, 32'h0, 5'd0);
    out_r("rst", 1'b0, 32'h0, 5'd0);
    $display("reset: outputs cleared");

    rst_n = 1'b1; #1;
    rdy_f("first", 3'b001);
    rdy_r("first", 3'b001);
    $display("release: first grant ch0 on both");

    // Round-robin: all valid -> 1,2,0,1,2 (ptr already advanced past ch0).
    @(negedge clk); vf = 3'b000; #1;
    rdy_r("rr1", 3'b010); rdy_f("idle1", 3'b000);
    out_f("first", 1'b1, 32'hA0, 5'd1); out_r("first", 1'b1, 32'hA0, 5'd1);
    @(negedge clk); #1; rdy_r("rr2", 3'b100); out_r("rr1", 1'b1, 32'hA1, 5'd2);
    chk("idle_ena_f", 64'(bus_f.rf_wbck_o_ena), 64'(0));
    @(negedge clk); #1; rdy_r("rr3", 3'b001); out_r("rr2", 1'b1, 32'hA2, 5'd3);
    @(negedge clk); #1; rdy_r("rr4", 3'b010); out_r("rr3", 1'b1, 32'hA0, 5'd1);
    @(negedge clk); #1; rdy_r("rr5", 3'b100); out_r("rr4", 1'b1, 32'hA1, 5'd2);
    $display("rr: order 0,1,2,0,1,2");
    @(negedge clk); vr = 3'b101; #1; rdy_r("rr101a", 3'b001); out_r("rr5", 1'b1, 32'hA2, 5'd3);
    @(negedge clk); #1; rdy_r("rr101b", 3'b100); out_r("rr101a", 1'b1, 32'hA0, 5'd1);
    @(negedge clk); #1; rdy_r("rr101c", 3'b001); out_r("rr101b", 1'b1, 32'hA2, 5'd3);
    @(negedge clk); vr = 3'b000; #1; rdy_r("rridle", 3'b000); out_r("rr101c", 1'b1, 32'hA0, 5'd1);
    @(negedge clk); #1; out_r("rrhold", 1'b0, 32'hA0, 5'd1);
    $display("rr: valid=101 -> 0,2,0; outputs hold with no grant");

    // Fixed priority: ch1 beats ch2, then ch2 after ch1 drops.
    wd[1] = 32'h11; rd[1] = 5'd3; wd[2] = 32'h22; rd[2] = 5'd4;
    vf = 3'b110; #1; rdy_f("fx110", 3'b010);
    @(negedge clk); vf = 3'b100; #1; rdy_f("fx100", 3'b100); out_f("fx110", 1'b1, 32'h11, 5'd3);
    @(negedge clk); vf = 3'b000; #1; rdy_f("fx000", 3'b000); out_f("fx100", 1'b1, 32'h22, 5'd4);
    $display("fixed: ch1 then ch2");

    // Aging: ch0 and ch2 both valid; ch2 blocked 8 cycles then aged.
    wd[0] = 32'h50; rd[0] = 5'd6;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); vf = 3'b101; #1;
      rdy_f($sformatf("age_blk%0d", k), 3'b001);
    end
    @(negedge clk); #1; rdy_f("age_win", 3'b100); out_f("age_blk7", 1'b1, 32'h50, 5'd6);
    @(negedge clk); #1; rdy_f("age_after", 3'b001); out_f("age_win", 1'b1, 32'h22, 5'd4);
    @(negedge clk); vf = 3'b000; #1; rdy_f("age_idle", 3'b000); out_f("age_after", 1'b1, 32'h50, 5'd6);
    $display("fixed: ch2 aged after 8 blocked cycles, then ch0 again");

    // x0 write consumed without enable, then a real write to x5.
    @(negedge clk); wd[0] = 32'hDEAD; rd[0] = 5'd0; vf = 3'b001; #1; rdy_f("x0", 3'b001);
    @(negedge clk); wd[0] = 32'hBEEF; rd[0] = 5'd5; #1; rdy_f("x5", 3'b001);
    out_f("x0", 1'b0, 32'hDEAD, 5'd0);
    @(negedge clk); vf = 3'b000; #1; out_f("x5", 1'b1, 32'hBEEF, 5'd5);
    $display("x0: handshake without enable, x5 enabled");

    // Reset mid-operation: grant ch1, then reset; pending write is cancelled.
    @(negedge clk); vf = 3'b010; #1; rdy_f("mid_g", 3'b010);
    @(negedge clk); rst_n = 1'b0; vf = 3'b000; #1;
    rdy_f("mid_rst", 3'b000); rdy_r("mid_rst", 3'b000);
    out_f("mid_g", 1'b1, 32'h11, 5'd3);
    @(negedge clk); rst_n = 1'b1; vr = 3'b111; #1;
    out_f("mid_clr", 1'b0, 32'h0, 5'd0);
    chk("mid_clr_ena_r", 64'(bus_r.rf_wbck_o_ena), 64'(0));
    rdy_f("mid_post", 3'b000);
    rdy_r("mid_ptr0", 3'b001);
    @(negedge clk); vr = 3'b000; #1;
    rdy_r("post_idle", 3'b000);
    out_r("post_g", 1'b1, 32'hBEEF, 5'd5);
    $display("mid reset: output cancelled, rr pointer back at ch0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_wbck_arb.md
Name: ex_wbck_arb

Overview:
N-channel integer register-file writeback arbiter, parametrised successor of the two-source ALU/long-pipe writeback mux. It accepts valid/ready writeback requests from NCH producers (ALU, long-pipe, and future units such as a divider or CSR path) and grants one per cycle. Arbitration is fixed-priority with anti-starvation aging, or round-robin. The granted write drives a registered single-port regfile write interface with one cycle of latency.

Parameters:
NCH, 3, number of writeback channels (2..8); channel 0 has the highest fixed priority
XLEN, 32, data width (matches E203_XLEN)
RFIDX_W, 5, register index width (matches E203_RFIDX_WIDTH)
RR_MODE, 0, 0 = fixed priority with aging, 1 = round-robin
STARVE_MAX, 8, fixed mode only: consecutive blocked cycles before a channel is aged (1..15)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous active-low reset
wbck_i_valid  in  NCH  per-channel writeback request
wbck_i_ready  out  NCH  per-channel grant/accept
wbck_i_wdat  in  NCH*XLEN  packed write data; channel i occupies [i*XLEN +: XLEN]
wbck_i_rdidx  in  NCH*RFIDX_W  packed destination index; channel i occupies [i*RFIDX_W +: RFIDX_W]
rf_wbck_o_ena  out  1  registered regfile write enable
rf_wbck_o_wdat  out  XLEN  registered write data
rf_wbck_o_rdidx  out  RFIDX_W  registered write index

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is synchronous and active-low. While rst_n=0 at a clock edge:
  - rf_wbck_o_ena=0, rf_wbck_o_wdat=0, rf_wbck_o_rdidx=0
  - RR pointer=0; all aging counters=0
- Grant logic:
  - Combinational: grant is one-hot or zero, and wbck_i_ready = grant.
  - At most one ready bit per cycle; a ready bit is never asserted for a channel with valid=0.
  - The regfile always accepts, so any valid channel that wins is accepted in the same cycle.
- Grant is a function of current valid and registered state only; there is no combinational path from the output registers back to ready.
- During reset cycles, ready is still computed from reset state; producers must hold valid low during reset.
- Fixed mode (RR_MODE=0):
  - Each channel has a counter cnt[i] (4 bits).
  - If valid[i]&~ready[i]: cnt[i] <= min(cnt[i]+1, STARVE_MAX). Otherwise cnt[i] <= 0.
  - Channel i is aged when cnt[i]==STARVE_MAX.
  - If any valid channel is aged, the lowest-index aged valid channel wins. Otherwise the lowest-index valid channel wins.
- Round-robin mode (RR_MODE=1):
  - Pointer ptr in 0..NCH-1. The search starts at ptr and wraps past NCH-1 to 0; the first valid channel wins.
  - On a grant to channel k, ptr <= (k+1) mod NCH. With no grant, ptr holds.
  - Aging counters are held at 0.
- Output stage, one-cycle latency, on each edge:
  - If a grant occurred: rf_wbck_o_wdat/rdidx <= selected channel's data/index, and rf_wbck_o_ena <= (rdidx != 0). Writes to x0 are consumed (handshake completes) but not enabled.
  - If there was no grant: rf_wbck_o_ena <= 0 and wdat/rdidx hold their previous values.
- Simultaneous events: all valid in one cycle → exactly one grant. Losers keep valid asserted with stable data (producer rule) and are not dropped.
- Reset mid-operation: a pending output write is cancelled (ena=0 the following cycle). An in-flight producer request is not accepted during reset.

Test Plan:
- Reset: hold rst_n=0 two cycles with all valid=1 → ena=0, wdat=0, rdidx=0 after the edge; release, then first grant goes to ch0 (fixed mode).
- Fixed priority, NCH=3: valid=3'b110, ch1 wdat=0x11/rd=3, ch2 wdat=0x22/rd=4 → ready=3'b010; next cycle ena=1, wdat=0x11, rdidx=3; after ch1 drops valid → ch2 granted, then ena=1, wdat=0x22, rdidx=4.
- Aging, STARVE_MAX=8: ch0 and ch2 continuously valid → ch2 blocked 8 cycles, granted on the 9th cycle (cnt=8), cnt[2] returns to 0, then ch0 wins again.
- Round-robin, NCH=3, all valid continuously → grant order 0,1,2,0,1,2; with valid=3'b101 after granting ch0 → ch2 next, then ch0.
- x0 write: single request rd=0, wdat=0xDEAD → ready=1, next cycle ena=0, rdidx=0 captured; a following request rd=5 → ena=1, rdidx=5.
- Reset mid-operation: grant ch1 at cycle t, assert rst_n=0 at t+1 → ena=0 at t+2, ptr/cnt=0, no ready asserted.
